// File: rtl/wb_dest_ctrl.sv
// Writeback sequencer: routes one accepted result to the register file, the
// data-memory write channel (req/ack with timeout) or a PC load plus flush.
module wb_dest_ctrl #(
   parameter int DATA_W       = 32,
   parameter int RADDR_W      = 5,
   parameter int MADDR_W      = 32,
   parameter int MEM_TIMEOUT  = 16,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [1:0]         in_sel,
   input  logic [DATA_W-1:0]  in_data,
   input  logic [RADDR_W-1:0] in_raddr,
   input  logic [MADDR_W-1:0] in_maddr,
   output logic               reg_we,
   output logic [RADDR_W-1:0] reg_addr,
   output logic [DATA_W-1:0]  reg_data,
   output logic               mem_req,
   output logic [MADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0]  mem_data,
   input  logic               mem_ack,
   output logic               mem_err,
   output logic               pc_load,
   output logic [DATA_W-1:0]  pc_value,
   output logic               flush
);

   localparam int TCNT_W = $clog2(MEM_TIMEOUT + 1) + 1;
   localparam int FCNT_W = $clog2(FLUSH_CYCLES + 1) + 1;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_FLUSH    = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [TCNT_W-1:0]  tcnt_q, tcnt_d;
   logic [FCNT_W-1:0]  fcnt_q, fcnt_d;
   logic               reg_we_q, reg_we_d;
   logic [RADDR_W-1:0] reg_addr_q, reg_addr_d;
   logic [DATA_W-1:0]  reg_data_q, reg_data_d;
   logic               mem_req_q, mem_req_d;
   logic [MADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]  mem_data_q, mem_data_d;
   logic               mem_err_q, mem_err_d;
   logic               pc_load_q, pc_load_d;
   logic [DATA_W-1:0]  pc_value_q, pc_value_d;
   logic               flush_q, flush_d;
   logic               accept_s;

   // Ready depends only on state (and reset), never on in_valid.
   assign in_ready = (state_q == ST_IDLE) && !rst;
   assign accept_s = in_valid && in_ready;

   // Next-state and next-output logic.
   always_comb begin
      state_d    = state_q;
      tcnt_d     = tcnt_q;
      fcnt_d     = fcnt_q;
      reg_we_d   = 1'b0;
      reg_addr_d = reg_addr_q;
      reg_data_d = reg_data_q;
      mem_req_d  = mem_req_q;
      mem_addr_d = mem_addr_q;
      mem_data_d = mem_data_q;
      mem_err_d  = 1'b0;
      pc_load_d  = 1'b0;
      pc_value_d = pc_value_q;
      flush_d    = flush_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               case (in_sel)
                  2'b01, 2'b11: begin
                     reg_we_d   = 1'b1;
                     reg_addr_d = in_raddr;
                     reg_data_d = in_data;
                  end
                  2'b10: begin
                     state_d    = ST_MEM_WAIT;
                     mem_req_d  = 1'b1;
                     mem_addr_d = in_maddr;
                     mem_data_d = in_data;
                     tcnt_d     = TCNT_W'(1);
                  end
                  2'b00: begin
                     state_d    = ST_FLUSH;
                     pc_load_d  = 1'b1;
                     pc_value_d = in_data;
                     flush_d    = 1'b1;
                     fcnt_d     = FCNT_W'(1);
                  end
                  default: begin
                     state_d = ST_IDLE;
                  end
               endcase
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_MEM_WAIT: begin
            // An ack in the timeout cycle still completes the write.
            if (mem_ack) begin
               mem_req_d = 1'b0;
               state_d   = ST_IDLE;
            end else if ((MEM_TIMEOUT != 0) && (tcnt_q == TCNT_W'(MEM_TIMEOUT))) begin
               mem_req_d = 1'b0;
               mem_err_d = 1'b1;
               state_d   = ST_IDLE;
            end else if (MEM_TIMEOUT != 0) begin
               tcnt_d = tcnt_q + TCNT_W'(1);
            end else begin
               tcnt_d = tcnt_q;
            end
         end
         ST_FLUSH: begin
            if (fcnt_q == FCNT_W'(FLUSH_CYCLES)) begin
               flush_d = 1'b0;
               state_d = ST_IDLE;
            end else begin
               fcnt_d = fcnt_q + FCNT_W'(1);
            end
         end
         default: begin
            state_d   = ST_IDLE;
            mem_req_d = 1'b0;
            flush_d   = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         tcnt_q     <= '0;
         fcnt_q     <= '0;
         reg_we_q   <= 1'b0;
         reg_addr_q <= '0;
         reg_data_q <= '0;
         mem_req_q  <= 1'b0;
         mem_addr_q <= '0;
         mem_data_q <= '0;
         mem_err_q  <= 1'b0;
         pc_load_q  <= 1'b0;
         pc_value_q <= '0;
         flush_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         tcnt_q     <= tcnt_d;
         fcnt_q     <= fcnt_d;
         reg_we_q   <= reg_we_d;
         reg_addr_q <= reg_addr_d;
         reg_data_q <= reg_data_d;
         mem_req_q  <= mem_req_d;
         mem_addr_q <= mem_addr_d;
         mem_data_q <= mem_data_d;
         mem_err_q  <= mem_err_d;
         pc_load_q  <= pc_load_d;
         pc_value_q <= pc_value_d;
         flush_q    <= flush_d;
      end
   end

   assign reg_we   = reg_we_q;
   assign reg_addr = reg_addr_q;
   assign reg_data = reg_data_q;
   assign mem_req  = mem_req_q;
   assign mem_addr = mem_addr_q;
   assign mem_data = mem_data_q;
   assign mem_err  = mem_err_q;
   assign pc_load  = pc_load_q;
   assign pc_value = pc_value_q;
   assign flush    = flush_q;

endmodule

// File: tb/tb_wb_dest_ctrl.sv
// Self-checking bench for wb_dest_ctrl: directed cases plus randomized
// transactions, expectations built per transaction from the sink rules.
module tb_wb_dest_ctrl;

   localparam int DW = 32;
   localparam int RW = 5;
   localparam int MW = 32;
   localparam int TO = 4;
   localparam int FC = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [1:0]    in_sel;
   logic [DW-1:0] in_data;
   logic [RW-1:0] in_raddr;
   logic [MW-1:0] in_maddr;
   logic          reg_we;
   logic [RW-1:0] reg_addr;
   logic [DW-1:0] reg_data;
   logic          mem_req;
   logic [MW-1:0] mem_addr;
   logic [DW-1:0] mem_data;
   logic          mem_ack;
   logic          mem_err;
   logic          pc_load;
   logic [DW-1:0] pc_value;
   logic          flush;

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;

   // Reference copies of the held data buses
   logic [RW-1:0] m_reg_addr;
   logic [DW-1:0] m_reg_data;
   logic [MW-1:0] m_mem_addr;
   logic [DW-1:0] m_mem_data;
   logic [DW-1:0] m_pc;

   wb_dest_ctrl #(
      .DATA_W(DW), .RADDR_W(RW), .MADDR_W(MW),
      .MEM_TIMEOUT(TO), .FLUSH_CYCLES(FC)
   ) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_sel(in_sel), .in_data(in_data), .in_raddr(in_raddr), .in_maddr(in_maddr),
      .reg_we(reg_we), .reg_addr(reg_addr), .reg_data(reg_data),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_data(mem_data),
      .mem_ack(mem_ack), .mem_err(mem_err),
      .pc_load(pc_load), .pc_value(pc_value), .flush(flush)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic rdy, input logic rwe,
                          input logic mreq, input logic merr, input logic pcl,
                          input logic fl);
      chk({tag, ".in_ready"}, in_ready, rdy);
      chk({tag, ".reg_we"},   reg_we,   rwe);
      chk({tag, ".mem_req"},  mem_req,  mreq);
      chk({tag, ".mem_err"},  mem_err,  merr);
      chk({tag, ".pc_load"},  pc_load,  pcl);
      chk({tag, ".flush"},    flush,    fl);
      chk({tag, ".reg_addr"}, reg_addr, m_reg_addr);
      chk({tag, ".reg_data"}, reg_data, m_reg_data);
      chk({tag, ".mem_addr"}, mem_addr, m_mem_addr);
      chk({tag, ".mem_data"}, mem_data, m_mem_data);
      chk({tag, ".pc_value"}, pc_value, m_pc);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_reg_addr = '0;
      m_reg_data = '0;
      m_mem_addr = '0;
      m_mem_data = '0;
      m_pc       = '0;
   endtask

   // Register write: pulse in the cycle after the transfer; ready stays high.
   task automatic do_reg(input logic [1:0] sel, input logic [RW-1:0] ra, input logic [DW-1:0] d);
      in_valid = 1'b1;
      in_sel   = sel;
      in_raddr = ra;
      in_data  = d;
      in_maddr = $urandom;
      step();
      in_valid   = 1'b0;
      m_reg_addr = ra;
      m_reg_data = d;
      chk_all("reg", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // Memory write; ack_at = request cycle carrying the ack (0 = never).
   task automatic do_mem(input logic [MW-1:0] a, input logic [DW-1:0] d, input int ack_at);
      bit timed_out;
      in_valid = 1'b1;
      in_sel   = 2'b10;
      in_maddr = a;
      in_data  = d;
      in_raddr = $urandom;
      step();
      m_mem_addr = a;
      m_mem_data = d;
      timed_out  = 1'b1;
      for (int k = 1; k <= TO; k++) begin
         in_valid = 1'($urandom);
         in_sel   = 2'($urandom);
         mem_ack  = (k == ack_at);
         chk_all("mem_wait", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
         step();
         if (k == ack_at) begin
            timed_out = 1'b0;
            break;
         end
      end
      in_valid = 1'b0;
      mem_ack  = 1'b0;
      chk_all("mem_done", 1'b1, 1'b0, 1'b0, timed_out, 1'b0, 1'b0);
   endtask

   // PC load: one pc_load pulse, flush for FC cycles, then ready again.
   task automatic do_pc(input logic [DW-1:0] d);
      in_valid = 1'b1;
      in_sel   = 2'b00;
      in_data  = d;
      step();
      in_valid = 1'b0;
      m_pc     = d;
      chk_all("pc_first", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      for (int f = 2; f <= FC; f++) begin
         mem_ack = 1'($urandom);
         step();
         chk_all("pc_flush", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      end
      mem_ack = 1'b0;
      step();
      chk_all("pc_done", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic idle_cycle();
      in_valid = 1'b0;
      in_sel   = 2'($urandom);
      mem_ack  = 1'($urandom);
      step();
      mem_ack = 1'b0;
      chk_all("idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      in_sel   = 2'b01;
      in_data  = '0;
      in_raddr = '0;
      in_maddr = '0;
      mem_ack  = 1'b0;
      model_reset();

      // Reset held two cycles
      step();
      chk_all("rst1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      chk_all("rst2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      #1;
      chk("rst_release.in_ready", in_ready, 1'b1);
      idle_cycle();

      // Back-to-back register burst
      do_reg(2'b01, 5'd1, 32'h0000_000A);
      do_reg(2'b01, 5'd2, 32'h0000_000B);
      do_reg(2'b01, 5'd3, 32'h0000_000C);
      idle_cycle();

      // Memory write acked on the third request cycle
      do_mem(32'h0000_0100, 32'hDEAD_BEEF, 3);
      idle_cycle();

      // Timeout with no ack, then ack exactly at the limit
      do_mem(32'h0000_0200, 32'h1234_5678, 0);
      idle_cycle();
      do_mem(32'h0000_0300, 32'hCAFE_F00D, TO);
      idle_cycle();

      // PC load
      do_pc(32'h0000_0400);
      idle_cycle();

      // Reset during the second MEM_WAIT cycle
      in_valid = 1'b1;
      in_sel   = 2'b10;
      in_maddr = 32'h0000_0500;
      in_data  = 32'h5555_AAAA;
      step();
      in_valid   = 1'b0;
      m_mem_addr = 32'h0000_0500;
      m_mem_data = 32'h5555_AAAA;
      chk_all("rstmem_c1", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      chk_all("rstmem_c2", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      rst = 1'b1;
      step();
      model_reset();
      chk_all("rstmem_after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      step();
      chk_all("rstmem_idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Randomized mix of transactions
      for (int t = 0; t < 60; t++) begin
         case ($urandom_range(3, 0))
            0: do_pc($urandom);
            1: do_reg(2'b01, 5'($urandom), $urandom);
            2: do_mem($urandom, $urandom, int'($urandom_range(6, 0)));
            3: do_reg(2'b11, 5'($urandom), $urandom);
            default: idle_cycle();
         endcase
         if ($urandom_range(2, 0) == 0) idle_cycle();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
